// File: rtl/bcd_seven_seg_decoder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_seg_pkg
//  Description : Shared 7-segment glyph constants, the segment vector type
//                and a polarity helper for the BCD 7-segment decoder.
//  Revision    : 1.0  initial release
// ============================================================================
package bcd_seg_pkg;

    // Segment vector ordered {a,b,c,d,e,f,g}; bit 6 is segment a (top).
    typedef logic [6:0] seg7_t;

    // Decimal glyphs, 1 = segment lit.
    localparam seg7_t SEG_0     = 7'b1111110;
    localparam seg7_t SEG_1     = 7'b0110000;
    localparam seg7_t SEG_2     = 7'b1101101;
    localparam seg7_t SEG_3     = 7'b1111001;
    localparam seg7_t SEG_4     = 7'b0110011;
    localparam seg7_t SEG_5     = 7'b1011011;
    localparam seg7_t SEG_6     = 7'b1011111;
    localparam seg7_t SEG_7     = 7'b1110000;
    localparam seg7_t SEG_8     = 7'b1111111;
    localparam seg7_t SEG_9     = 7'b1111011;

    // Hexadecimal glyphs (A, b, C, d, E, F).
    localparam seg7_t SEG_A     = 7'b1110111;
    localparam seg7_t SEG_B     = 7'b0011111;
    localparam seg7_t SEG_C     = 7'b1001110;
    localparam seg7_t SEG_D     = 7'b0111101;
    localparam seg7_t SEG_E     = 7'b1001111;
    localparam seg7_t SEG_F     = 7'b1000111;

    // All segments dark.
    localparam seg7_t SEG_BLANK = 7'b0000000;

    // Map a lit-high glyph onto the pad polarity (common anode inverts).
    function automatic seg7_t seg_polarity(input seg7_t glyph, input bit invert);
        return invert ? ~glyph : glyph;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_seven_seg_decoder_if.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_seven_seg_decoder_if
//  Description : Bundle of the BCD nibble inputs {A,B,C,D} and the seven
//                segment drives a..g for one display digit.
//  Revision    : 1.0  initial release
// ============================================================================
interface bcd_seven_seg_decoder_if;

    // BCD nibble, A is the MSB.
    logic A;
    logic B;
    logic C;
    logic D;

    // Segment drives: a top, b upper-right, c lower-right, d bottom,
    // e lower-left, f upper-left, g middle.
    logic a;
    logic b;
    logic c;
    logic d;
    logic e;
    logic f;
    logic g;

    // Upstream logic supplying the digit and observing the pads.
    modport master (
        output A, B, C, D,
        input  a, b, c, d, e, f, g
    );

    // The decoder itself.
    modport slave (
        input  A, B, C, D,
        output a, b, c, d, e, f, g
    );

endinterface

`default_nettype wire

// File: rtl/bcd_seven_seg_decoder_lut.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_seg_lut
//  Description : Purely combinational nibble -> glyph lookup. Codes 10..15
//                show A..F when HEX_MODE=1 and blank otherwise. Any nibble
//                that matches no case item (including X/Z bits) blanks.
//  Revision    : 1.0  initial release
// ============================================================================
module bcd_seg_lut
    import bcd_seg_pkg::*;
#(
    parameter bit HEX_MODE = 1'b0
) (
    input  wire logic [3:0] nibble_i,
    output seg7_t           seg_o
);

    // Glyphs shown for codes 10..15; chosen once at elaboration time.
    seg7_t hex_a_w;
    seg7_t hex_b_w;
    seg7_t hex_c_w;
    seg7_t hex_d_w;
    seg7_t hex_e_w;
    seg7_t hex_f_w;

    generate
        if (HEX_MODE) begin : g_hex_glyphs
            assign hex_a_w = SEG_A;
            assign hex_b_w = SEG_B;
            assign hex_c_w = SEG_C;
            assign hex_d_w = SEG_D;
            assign hex_e_w = SEG_E;
            assign hex_f_w = SEG_F;
        end else begin : g_blank_glyphs
            assign hex_a_w = SEG_BLANK;
            assign hex_b_w = SEG_BLANK;
            assign hex_c_w = SEG_BLANK;
            assign hex_d_w = SEG_BLANK;
            assign hex_e_w = SEG_BLANK;
            assign hex_f_w = SEG_BLANK;
        end
    endgenerate

    // Table lookup; blank is the default so unknown inputs never leak X.
    always_comb begin
        seg_o = SEG_BLANK;
        case (nibble_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            4'd10:   seg_o = hex_a_w;
            4'd11:   seg_o = hex_b_w;
            4'd12:   seg_o = hex_c_w;
            4'd13:   seg_o = hex_d_w;
            4'd14:   seg_o = hex_e_w;
            4'd15:   seg_o = hex_f_w;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/bcd_seven_seg_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_seven_seg_decoder
//  Description : Registered BCD-to-7-segment decoder for one digit. Lookup,
//                optional common-anode inversion, then a 7-bit register
//                with asynchronous reset to the dark pattern.
//  Revision    : 1.0  initial release
// ============================================================================
module bcd_seven_seg_decoder
    import bcd_seg_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b0,
    parameter bit HEX_MODE   = 1'b0
) (
    input  wire logic               clk,
    input  wire logic               rst,
    bcd_seven_seg_decoder_if.slave  bus
);

    // Dark pattern as seen at the pads for the chosen polarity.
    localparam seg7_t SEG_OFF = seg_polarity(SEG_BLANK, ACTIVE_LOW);

    logic [3:0] nibble_w;
    seg7_t      glyph_w;
    seg7_t      seg_d;
    seg7_t      seg_q;

    assign nibble_w = {bus.A, bus.B, bus.C, bus.D};

    bcd_seg_lut #(
        .HEX_MODE (HEX_MODE)
    ) u_lut (
        .nibble_i (nibble_w),
        .seg_o    (glyph_w)
    );

    // Polarity is applied ahead of the register so the pads see only flop outputs.
    assign seg_d = seg_polarity(glyph_w, ACTIVE_LOW);

    // Output register; reset darkens the digit without waiting for a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_q <= SEG_OFF;
        end else begin
            seg_q <= seg_d;
        end
    end

    assign bus.a = seg_q[6];
    assign bus.b = seg_q[5];
    assign bus.c = seg_q[4];
    assign bus.d = seg_q[3];
    assign bus.e = seg_q[2];
    assign bus.f = seg_q[1];
    assign bus.g = seg_q[0];

endmodule

`default_nettype wire

// File: tb/tb_bcd_seven_seg_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_seven_seg_decoder
//  Description : Self-checking bench for bcd_seven_seg_decoder. Four copies
//                cover every ACTIVE_LOW / HEX_MODE combination and share the
//                same nibble stream; a glyph-table model predicts outputs.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bcd_seven_seg_decoder;

    logic clk;
    logic rst;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] cur_nib;

    // Index k: ACTIVE_LOW = k[1], HEX_MODE = k[0].
    bcd_seven_seg_decoder_if u_if0 ();
    bcd_seven_seg_decoder_if u_if1 ();
    bcd_seven_seg_decoder_if u_if2 ();
    bcd_seven_seg_decoder_if u_if3 ();

    bcd_seven_seg_decoder #(.ACTIVE_LOW(1'b0), .HEX_MODE(1'b0)) u_dut0 (.clk(clk), .rst(rst), .bus(u_if0));
    bcd_seven_seg_decoder #(.ACTIVE_LOW(1'b0), .HEX_MODE(1'b1)) u_dut1 (.clk(clk), .rst(rst), .bus(u_if1));
    bcd_seven_seg_decoder #(.ACTIVE_LOW(1'b1), .HEX_MODE(1'b0)) u_dut2 (.clk(clk), .rst(rst), .bus(u_if2));
    bcd_seven_seg_decoder #(.ACTIVE_LOW(1'b1), .HEX_MODE(1'b1)) u_dut3 (.clk(clk), .rst(rst), .bus(u_if3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference glyphs written straight from the digit drawings, abcdefg.
    localparam logic [6:0] GLYPHS [0:15] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    function automatic logic [6:0] model_seg(input int nib, input bit hex, input bit al);
        logic [6:0] lit;
        lit = (nib <= 9 || hex) ? GLYPHS[nib] : 7'b0000000;
        return al ? ~lit : lit;
    endfunction

    function automatic logic [6:0] dut_seg(input int k);
        case (k)
            0:       return {u_if0.a, u_if0.b, u_if0.c, u_if0.d, u_if0.e, u_if0.f, u_if0.g};
            1:       return {u_if1.a, u_if1.b, u_if1.c, u_if1.d, u_if1.e, u_if1.f, u_if1.g};
            2:       return {u_if2.a, u_if2.b, u_if2.c, u_if2.d, u_if2.e, u_if2.f, u_if2.g};
            default: return {u_if3.a, u_if3.b, u_if3.c, u_if3.d, u_if3.e, u_if3.f, u_if3.g};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] nib);
        cur_nib = nib;
        {u_if0.A, u_if0.B, u_if0.C, u_if0.D} = nib;
        {u_if1.A, u_if1.B, u_if1.C, u_if1.D} = nib;
        {u_if2.A, u_if2.B, u_if2.C, u_if2.D} = nib;
        {u_if3.A, u_if3.B, u_if3.C, u_if3.D} = nib;
    endtask

    // All four copies against the model for the nibble captured at the last edge.
    task automatic check_all(input string tag, input logic [3:0] nib);
        for (int k = 0; k < 4; k++)
            chk($sformatf("%s[al=%0d,hex=%0d,nib=%0d]", tag, k / 2, k % 2, nib),
                dut_seg(k), model_seg(int'(nib), bit'(k % 2), bit'(k / 2)));
    endtask

    task automatic check_dark(input string tag);
        for (int k = 0; k < 4; k++)
            chk($sformatf("%s[al=%0d,hex=%0d]", tag, k / 2, k % 2),
                dut_seg(k), (k / 2 == 1) ? 7'b1111111 : 7'b0000000);
    endtask

    // Present a nibble at the falling edge, check just after the next rising edge.
    task automatic step(input string tag, input logic [3:0] nib);
        @(negedge clk);
        drive(nib);
        @(posedge clk);
        #1;
        check_all(tag, nib);
    endtask

    initial begin
        // Asynchronous reset before any clock edge.
        rst = 1'b1;
        drive(4'b0101);
        #1;
        check_dark("reset_async");

        // First edge after release loads the decoded 5.
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("reset_release_5", dut_seg(0), 7'b1011011);
        check_all("reset_release", 4'b0101);

        // Decimal sweep, ten cycles per digit.
        for (int dgt = 0; dgt < 10; dgt++)
            for (int r = 0; r < 10; r++)
                step("sweep", 4'(dgt));
        step("digit8", 4'd8);
        chk("digit8_lit", dut_seg(0), 7'b1111111);
        step("digit1", 4'd1);
        chk("digit1_lit", dut_seg(0), 7'b0110000);

        // Codes 10..15 in every configuration.
        for (int cde = 10; cde < 16; cde++)
            for (int r = 0; r < 3; r++)
                step("invalid", 4'(cde));
        step("hexA", 4'b1010);
        chk("hexA_glyph", dut_seg(1), 7'b1110111);
        chk("hexA_blank", dut_seg(0), 7'b0000000);
        step("hexb", 4'b1011);
        chk("hexb_glyph", dut_seg(1), 7'b0011111);
        step("hexF", 4'b1111);
        chk("hexF_glyph", dut_seg(1), 7'b1000111);
        chk("code15_blank", dut_seg(0), 7'b0000000);
        step("al_zero", 4'b0000);
        chk("al_zero_glyph", dut_seg(2), 7'b0000001);

        // Random nibbles every cycle.
        for (int i = 0; i < 300; i++)
            step("random", 4'($urandom_range(0, 15)));

        // Mid-run reset between edges with inputs still toggling.
        for (int i = 0; i < 10; i++)
            step("pre_midrst", 4'($urandom_range(0, 15)));
        #3;
        rst = 1'b1;
        #1;
        check_dark("midrst_async");
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            drive(4'($urandom_range(0, 15)));
            @(posedge clk);
            #1;
            check_dark("midrst_hold");
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_all("midrst_release", cur_nib);
        for (int i = 0; i < 20; i++)
            step("post_midrst", 4'($urandom_range(0, 15)));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
